core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
- Multi-cycle control FSM that steps the core datapath: PC, instruction fetch, control unit, register file and ALU.
- Replaces the implicit every-cycle commit with explicit FETCH, DECODE, EXEC and WB phases.
- Issues a req/valid fetch handshake and latches the instruction register.
- Gates register-file and PC writes to a single WB cycle.
- Halts on ebreak; flags a fetch timeout.

Parameters:
- XLEN, 32, instruction/data width.
- FETCH_TIMEOUT, 255, max FETCH cycles without ifetch_valid before error; must be ≥1.
- CNT_W, 64, width of performance counters (used only with PERF_CNT_EN).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  enable to start or continue instruction issue.
- ifetch_req  out  1  fetch request to instruction memory.
- ifetch_valid  in  1  fetch data valid.
- ifetch_rdata  in  XLEN  fetched instruction.
- ir  out  XLEN  latched instruction; feeds the control unit.
- dec_reg_write  in  1  register write enable decoded from ir.
- dec_ebreak  in  1  ir decodes as ebreak.
- reg_we  out  1  register file write strobe.
- pc_we  out  1  PC update strobe.
- halted  out  1  sticky; ebreak retired.
- fetch_err  out  1  sticky; fetch timeout.
- state_o  out  3  current state encoding, for debug.
- cycle_cnt  out  CNT_W  cycles counted while active.
- instret_cnt  out  CNT_W  retired instructions.

Behaviour:
- Reset, sampled on the clk rising edge:
  - state=IDLE, ir=0, ifetch_req=0, reg_we=0, pc_we=0, halted=0, fetch_err=0, timeout counter=0, counters=0.
  - Reset asserted mid-operation aborts at that edge; no write strobe fires afterwards.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5, ERR=6. state_o reflects state combinationally.
- IDLE: all strobes 0. If run=1 → FETCH next cycle.
- FETCH:
  - ifetch_req=1, held until ifetch_valid is sampled high.
  - On valid: ir←ifetch_rdata, timeout counter cleared, → DECODE. Valid in the first FETCH cycle gives a 1-cycle fetch.
  - No valid: counter increments. When counter==FETCH_TIMEOUT-1 with valid still low → ERR; fetch_err=1 and ifetch_req=0 from the next cycle.
  - Valid on the same cycle as the timeout threshold: valid wins.
  - ifetch_valid outside FETCH is ignored.
- DECODE: one cycle for control-unit settle. dec_ebreak=1 → HALT with halted=1, no reg_we or pc_we. Otherwise → EXEC.
- EXEC: one cycle for ALU settle; no strobes.
- WB:
  - reg_we=dec_reg_write and pc_we=1 for exactly this cycle.
  - Then → FETCH if run=1, else → IDLE. The current instruction always completes regardless of run.
- HALT, ERR: terminal; only rst exits. Strobes 0, ifetch_req=0.
- Latency: minimum 4 cycles per instruction (FETCH, DECODE, EXEC, WB); each fetch wait cycle adds 1.
- Invariant: reg_we and pc_we are never high outside WB; ir changes only on an accepted fetch.

Optional Feature:
- Macro PERF_CNT_EN.
- When defined:
  - cycle_cnt increments every cycle the state is FETCH, DECODE, EXEC or WB.
  - instret_cnt increments on each WB cycle.
  - Both wrap modulo 2^CNT_W and reset to 0.
- When undefined: both ports remain and are tied to 0; no counter flops are inferred.

Decomposition:
- Package core_seq_pkg: state enum and encodings, state width constant, default FETCH_TIMEOUT.
- Sub-module fetch_timer: loadable and clearable counter with threshold compare, producing the timeout pulse; instantiated once.
- Counters stay inline under the macro.

Test Plan:
- Reset then run=1, ifetch_valid tied 1, rdata=0x00500093 (addi x1,x0,5), dec_reg_write=1 → states 1,2,3,4 repeating; reg_we and pc_we pulse once every 4 cycles; ir=0x00500093 after first FETCH.
- ifetch_valid delayed 3 cycles → ifetch_req held 4 cycles; WB occurs at cycle 7 after FETCH entry; exactly one pc_we pulse.
- dec_ebreak=1 with ir=0x00100073 → HALT after DECODE, halted=1, pc_we never pulses; run toggling has no effect until rst.
- FETCH_TIMEOUT=4, valid never asserted → ERR entered after 4 FETCH cycles, fetch_err=1, ifetch_req=0; valid on the 4th cycle instead → DECODE, no error.
- run dropped during EXEC → WB still pulses reg_we/pc_we, then IDLE; rst asserted during EXEC → no WB strobes, state=IDLE next cycle.
- PERF_CNT_EN defined, 10 instructions with zero-wait fetch → instret_cnt=10, cycle_cnt=40; undefined → both read 0.

Source files
------------

// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared constants for the core sequencer.
//   - State encodings (legacy-compatible localparams) and the state width.
//   - Default fetch timeout.
//   - is_active(): true for the states that count as active instruction issue.
package core_seq_pkg;

  localparam int unsigned StateW = 3;
  typedef logic [StateW-1:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StFetch  = 3'd1;
  localparam state_t StDecode = 3'd2;
  localparam state_t StExec   = 3'd3;
  localparam state_t StWb     = 3'd4;
  localparam state_t StHalt   = 3'd5;
  localparam state_t StErr    = 3'd6;

  localparam int unsigned FetchTimeoutDef = 255;

  function automatic logic is_active(state_t s);
    return (s == StFetch) || (s == StDecode) || (s == StExec) || (s == StWb);
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// core_sequencer_if: instruction fetch handshake between the sequencer and instruction memory.
//   ifetch_req   : fetch request, driven by the sequencer (master)
//   ifetch_valid : fetch data valid, driven by memory (slave)
//   ifetch_rdata : fetched instruction, driven by memory (slave)
interface core_sequencer_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            ifetch_req;
  logic            ifetch_valid;
  logic [XLEN-1:0] ifetch_rdata;

  modport master (
    output ifetch_req,
    input  ifetch_valid,
    input  ifetch_rdata
  );

  modport slave (
    input  ifetch_req,
    output ifetch_valid,
    output ifetch_rdata
  );

endinterface

// File: rtl/fetch_timer.sv
// fetch_timer: counts FETCH cycles spent waiting for ifetch_valid and pulses o_timeout on the
// cycle where the count reaches FETCH_TIMEOUT-1 while still waiting.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : clear the count (fetch accepted or not fetching)
//   i_inc        : a wait cycle is in progress
//   o_timeout    : combinational timeout pulse
module fetch_timer #(
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_timeout
);

  // The count never needs to exceed FETCH_TIMEOUT-1.
  localparam int unsigned CntW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [CntW-1:0] Thresh = CntW'(FETCH_TIMEOUT - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign o_timeout = i_inc && (r_cnt == Thresh);

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXEC/WB control FSM for the core datapath.
// Optional feature macro: PERF_CNT_EN (cycle and retired-instruction counters).
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_run                 : start / continue instruction issue
//   io_fetch              : fetch handshake (master side)
//   o_ir                  : latched instruction register
//   i_dec_reg_write       : decoded register write enable
//   i_dec_ebreak          : decoded ebreak
//   o_reg_we, o_pc_we     : write strobes, high only in WB
//   o_halted, o_fetch_err : sticky terminal flags
//   o_state               : current state, for debug
//   o_cycle_cnt           : active cycles (0 without PERF_CNT_EN)
//   o_instret_cnt         : retired instructions (0 without PERF_CNT_EN)
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned FETCH_TIMEOUT = FetchTimeoutDef,
  parameter int unsigned CNT_W         = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_run,
  core_sequencer_if.master   io_fetch,
  output logic [XLEN-1:0]    o_ir,
  input  logic               i_dec_reg_write,
  input  logic               i_dec_ebreak,
  output logic               o_reg_we,
  output logic               o_pc_we,
  output logic               o_halted,
  output logic               o_fetch_err,
  output logic [StateW-1:0]  o_state,
  output logic [CNT_W-1:0]   o_cycle_cnt,
  output logic [CNT_W-1:0]   o_instret_cnt
);

  state_t          r_state;
  state_t          w_state_next;
  logic [XLEN-1:0] r_ir;
  logic            w_in_fetch;
  logic            w_fetch_ok;
  logic            w_timeout;

  assign w_in_fetch = (r_state == StFetch);
  assign w_fetch_ok = w_in_fetch && io_fetch.ifetch_valid;

  fetch_timer #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_fetch_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (!w_in_fetch || io_fetch.ifetch_valid),
    .i_inc    (w_in_fetch && !io_fetch.ifetch_valid),
    .o_timeout(w_timeout)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (i_run) w_state_next = StFetch;
      // A valid on the threshold cycle still wins over the timeout.
      StFetch: begin
        if (io_fetch.ifetch_valid) w_state_next = StDecode;
        else if (w_timeout)        w_state_next = StErr;
      end
      StDecode: w_state_next = i_dec_ebreak ? StHalt : StExec;
      StExec:   w_state_next = StWb;
      StWb:     w_state_next = i_run ? StFetch : StIdle;
      StHalt:   w_state_next = StHalt;
      StErr:    w_state_next = StErr;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ir <= '0;
    end else if (w_fetch_ok) begin
      r_ir <= io_fetch.ifetch_rdata;
    end
  end

  // Moore outputs: strobes and flags decode straight from the state register.
  assign io_fetch.ifetch_req = w_in_fetch;
  assign o_ir                = r_ir;
  assign o_reg_we            = (r_state == StWb) && i_dec_reg_write;
  assign o_pc_we             = (r_state == StWb);
  assign o_halted            = (r_state == StHalt);
  assign o_fetch_err         = (r_state == StErr);
  assign o_state             = r_state;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (is_active(r_state)) r_cycle_cnt   <= r_cycle_cnt + CNT_W'(1);
      if (r_state == StWb)    r_instret_cnt <= r_instret_cnt + CNT_W'(1);
    end
  end

  assign o_cycle_cnt   = r_cycle_cnt;
  assign o_instret_cnt = r_instret_cnt;
`else
  assign o_cycle_cnt   = '0;
  assign o_instret_cnt = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: randomized self-checking bench for core_sequencer.
// Expected behaviour is derived per instruction from its fetch wait count: FETCH lasts
// wait+1 cycles (or FETCH_TIMEOUT cycles then ERR), followed by DECODE, EXEC, WB.
module tb_core_sequencer;

  localparam int unsigned XLEN = 32;
  localparam int unsigned FT   = 4;
  localparam int unsigned CW   = 64;

  localparam logic [2:0] SIdle = 3'd0, SFetch = 3'd1, SDecode = 3'd2, SExec = 3'd3;
  localparam logic [2:0] SWb = 3'd4, SHalt = 3'd5, SErr = 3'd6;

`ifdef PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            run = 1'b0;
  logic            dec_reg_write = 1'b0;
  logic            dec_ebreak = 1'b0;
  logic [XLEN-1:0] ir;
  logic            reg_we, pc_we, halted, fetch_err;
  logic [2:0]      state;
  logic [CW-1:0]   cyc, ins;

  int total = 0;
  int bad = 0;

  logic [31:0]     exp_ir = '0;
  longint unsigned m_cyc = 0;
  longint unsigned m_ins = 0;

  core_sequencer_if #(.XLEN(XLEN)) bus ();

  core_sequencer #(
    .XLEN         (XLEN),
    .FETCH_TIMEOUT(FT),
    .CNT_W        (CW)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_run          (run),
    .io_fetch       (bus),
    .o_ir           (ir),
    .i_dec_reg_write(dec_reg_write),
    .i_dec_ebreak   (dec_ebreak),
    .o_reg_we       (reg_we),
    .o_pc_we        (pc_we),
    .o_halted       (halted),
    .o_fetch_err    (fetch_err),
    .o_state        (state),
    .o_cycle_cnt    (cyc),
    .o_instret_cnt  (ins)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Runs one instruction starting from the cycle after the tick that enters FETCH.
  task automatic exec_instr(input int w, input logic [31:0] instr, input logic regw,
                            input logic ebrk, input logic run_wb);
    bit            tmo;
    int            last;
    logic [2:0]    es;
    logic [31:0]   eir;
    logic [CW-1:0] ecyc, eins;
    tmo  = (w >= int'(FT));
    last = tmo ? int'(FT) : (ebrk ? w + 2 : w + 3);
    for (int c = 0; c <= last; c++) begin
      tick();
      if (tmo)              es = (c < int'(FT)) ? SFetch : SErr;
      else if (c <= w)      es = SFetch;
      else if (c == w + 1)  es = SDecode;
      else if (ebrk)        es = SHalt;
      else if (c == w + 2)  es = SExec;
      else                  es = SWb;
      bus.ifetch_valid = (es == SFetch) ? (!tmo && c == w) : 1'($urandom);
      bus.ifetch_rdata = (!tmo && c == w) ? instr : $urandom;
      dec_ebreak       = (es == SDecode) ? ebrk : 1'($urandom);
      dec_reg_write    = (es == SWb) ? regw : 1'($urandom);
      run              = (es == SWb) ? run_wb : 1'($urandom);
      #1;
      eir  = (!tmo && c > w) ? instr : exp_ir;
      ecyc = PerfEn ? CW'(m_cyc) : '0;
      eins = PerfEn ? CW'(m_ins) : '0;
      total++;
      if (state !== es) begin
        bad++; $display("FAIL state c=%0d w=%0d: got %0d want %0d", c, w, state, es);
      end
      total++;
      if (bus.ifetch_req !== (es == SFetch)) begin
        bad++; $display("FAIL ifetch_req c=%0d: got %b want %b", c, bus.ifetch_req, es == SFetch);
      end
      total++;
      if (pc_we !== (es == SWb)) begin
        bad++; $display("FAIL pc_we c=%0d: got %b want %b", c, pc_we, es == SWb);
      end
      total++;
      if (reg_we !== (es == SWb && regw)) begin
        bad++; $display("FAIL reg_we c=%0d: got %b want %b", c, reg_we, es == SWb && regw);
      end
      total++;
      if (halted !== (es == SHalt) || fetch_err !== (es == SErr)) begin
        bad++; $display("FAIL flags c=%0d: got halted=%b err=%b want %b %b", c, halted, fetch_err,
                        es == SHalt, es == SErr);
      end
      total++;
      if (ir !== eir) begin
        bad++; $display("FAIL ir c=%0d: got %h want %h", c, ir, eir);
      end
      total++;
      if (cyc !== ecyc || ins !== eins) begin
        bad++; $display("FAIL counters c=%0d: got cyc=%0d ins=%0d want %0d %0d", c, cyc, ins,
                        ecyc, eins);
      end
      if (es inside {SFetch, SDecode, SExec, SWb}) m_cyc++;
      if (es == SWb) m_ins++;
    end
    if (!tmo) exp_ir = instr;
  endtask

  task automatic idle_cycles(input int n, input logic go);
    for (int i = 0; i < n; i++) begin
      tick();
      run              = (i == n - 1) ? go : 1'b0;
      bus.ifetch_valid = 1'($urandom);
      bus.ifetch_rdata = $urandom;
      dec_reg_write    = 1'($urandom);
      dec_ebreak       = 1'($urandom);
      #1;
      total++;
      if (state !== SIdle || bus.ifetch_req !== 1'b0 || reg_we !== 1'b0 || pc_we !== 1'b0) begin
        bad++; $display("FAIL idle: got state=%0d req=%b reg_we=%b pc_we=%b want 0 0 0 0",
                        state, bus.ifetch_req, reg_we, pc_we);
      end
      total++;
      if (ir !== exp_ir) begin
        bad++; $display("FAIL idle ir: got %h want %h", ir, exp_ir);
      end
    end
  endtask

  task automatic do_reset(input logic go);
    tick();
    rst = 1'b1; run = 1'($urandom); bus.ifetch_valid = 1'b1; bus.ifetch_rdata = $urandom;
    dec_reg_write = 1'b1; dec_ebreak = 1'b0;
    tick();
    rst = 1'b0; run = go; bus.ifetch_valid = 1'b0; dec_reg_write = 1'b0;
    #1;
    exp_ir = '0; m_cyc = 0; m_ins = 0;
    total++;
    if (state !== SIdle || ir !== '0) begin
      bad++; $display("FAIL reset state/ir: got %0d %h want 0 0", state, ir);
    end
    total++;
    if (bus.ifetch_req !== 1'b0 || reg_we !== 1'b0 || pc_we !== 1'b0 || halted !== 1'b0 ||
        fetch_err !== 1'b0) begin
      bad++; $display("FAIL reset outputs: got req=%b reg_we=%b pc_we=%b halted=%b err=%b want 0",
                      bus.ifetch_req, reg_we, pc_we, halted, fetch_err);
    end
    total++;
    if (cyc !== '0 || ins !== '0) begin
      bad++; $display("FAIL reset counters: got %0d %0d want 0 0", cyc, ins);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    idle_cycles(3, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) exec_instr(0, 32'h0050_0093, 1'b1, 1'b0, i < 9);
    tick();
    #1;
    total++;
    if (state !== SIdle) begin
      bad++; $display("FAIL b2b end state: got %0d want 0", state);
    end
    total++;
    if (cyc !== (PerfEn ? 64'd40 : 64'd0) || ins !== (PerfEn ? 64'd10 : 64'd0)) begin
      bad++; $display("FAIL b2b counters: got cyc=%0d ins=%0d want %0d %0d", cyc, ins,
                      PerfEn ? 40 : 0, PerfEn ? 10 : 0);
    end
  endtask

  task automatic test_fetch_wait();
    do_reset(1'b1);
    exec_instr(3, $urandom, 1'b1, 1'b0, 1'b0);
    idle_cycles(2, 1'b0);
  endtask

  task automatic test_halt();
    do_reset(1'b1);
    exec_instr(int'($urandom_range(0, 2)), 32'h0010_0073, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      run = 1'($urandom); bus.ifetch_valid = 1'($urandom); dec_reg_write = 1'($urandom);
      #1;
      total++;
      if (state !== SHalt || halted !== 1'b1 || pc_we !== 1'b0 || reg_we !== 1'b0 ||
          bus.ifetch_req !== 1'b0) begin
        bad++; $display("FAIL halt hold: got state=%0d halted=%b pc_we=%b reg_we=%b req=%b",
                        state, halted, pc_we, reg_we, bus.ifetch_req);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset(1'b1);
    exec_instr(int'(FT), $urandom, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      run = 1'($urandom); bus.ifetch_valid = 1'($urandom);
      #1;
      total++;
      if (state !== SErr || fetch_err !== 1'b1 || bus.ifetch_req !== 1'b0 || pc_we !== 1'b0) begin
        bad++; $display("FAIL err hold: got state=%0d err=%b req=%b pc_we=%b",
                        state, fetch_err, bus.ifetch_req, pc_we);
      end
    end
    do_reset(1'b1);
    exec_instr(int'(FT) - 1, $urandom, 1'b1, 1'b0, 1'b0);
    idle_cycles(1, 1'b0);
  endtask

  task automatic test_rst_mid();
    do_reset(1'b1);
    dec_ebreak = 1'b0;
    tick();
    bus.ifetch_valid = 1'b1; bus.ifetch_rdata = 32'hdead_beef;
    #1;
    total++;
    if (state !== SFetch) begin
      bad++; $display("FAIL rst_mid fetch: got %0d want 1", state);
    end
    tick();
    bus.ifetch_valid = 1'b0; dec_ebreak = 1'b0;
    tick();
    #1;
    total++;
    if (state !== SExec) begin
      bad++; $display("FAIL rst_mid exec: got %0d want 3", state);
    end
    rst = 1'b1; dec_reg_write = 1'b1; run = 1'b1;
    tick();
    rst = 1'b0; run = 1'b0;
    #1;
    total++;
    if (state !== SIdle || reg_we !== 1'b0 || pc_we !== 1'b0 || ir !== '0) begin
      bad++; $display("FAIL rst_mid abort: got state=%0d reg_we=%b pc_we=%b ir=%h want 0 0 0 0",
                      state, reg_we, pc_we, ir);
    end
    exp_ir = '0; m_cyc = 0; m_ins = 0;
    idle_cycles(2, 1'b0);
  endtask

  task automatic test_random();
    logic rw;
    do_reset(1'b1);
    for (int i = 0; i < 25; i++) begin
      rw = ($urandom_range(0, 3) != 0);
      exec_instr(int'($urandom_range(0, 3)), $urandom, 1'($urandom), 1'b0, rw);
      if (!rw) idle_cycles(int'($urandom_range(1, 3)), 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.ifetch_valid = 1'b0;
    bus.ifetch_rdata = '0;
    test_reset();
    test_back_to_back();
    test_fetch_wait();
    test_halt();
    test_timeout();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
